// File: rtl/fir_serial.sv
// Time-multiplexed FIR: one signed MAC evaluates an NTAPS-tap output per accepted sample.
// Coefficients are runtime-loadable; input and output use valid/ready handshakes.
module fir_serial #(
    parameter int NTAPS = 74,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = DW + CW + $clog2(NTAPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DW-1:0]          in_sample,
    input  logic                          coef_we,
    input  logic [$clog2(NTAPS)-1:0]      coef_addr,
    input  logic signed [CW-1:0]          coef_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OW-1:0]          out_data
);

    localparam int AW = $clog2(NTAPS);
    localparam int PW = DW + CW;
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          wp_q, wp_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic signed [OW-1:0]   acc_q, acc_d;
    logic signed [OW-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q;
    logic                   in_ready_q;
    logic signed [DW-1:0]   dly_q  [NTAPS];
    logic signed [CW-1:0]   coef_q [NTAPS];

    logic [AW-1:0]          rd_idx_s;
    logic [AW-1:0]          wp_next_s;
    logic signed [PW-1:0]   prod_s;
    logic signed [OW-1:0]   sum_s;
    logic                   dly_we_s;
    logic                   coef_we_s;

    // Tap address, product and running sum for the current MAC step
    always_comb begin
        rd_idx_s  = '0;
        wp_next_s = '0;
        if (wp_q >= idx_q) begin
            rd_idx_s = wp_q - idx_q;
        end else begin
            rd_idx_s = wp_q + AW'(NTAPS) - idx_q;
        end
        if (wp_q == LAST_IDX) begin
            wp_next_s = '0;
        end else begin
            wp_next_s = wp_q + {{(AW-1){1'b0}}, 1'b1};
        end
        prod_s = PW'(dly_q[rd_idx_s]) * PW'(coef_q[idx_q]);
        sum_s  = acc_q + OW'(prod_s);
    end

    // Next-state logic; clr overrides the handshake and coefficient writes
    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        dly_we_s   = 1'b0;
        coef_we_s  = 1'b0;
        if (clr) begin
            state_d    = IDLE;
            wp_d       = '0;
            idx_d      = '0;
            acc_d      = '0;
            out_data_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    coef_we_s = coef_we && ({1'b0, coef_addr} < (AW+1)'(NTAPS));
                    if (in_valid && in_ready_q) begin
                        dly_we_s = 1'b1;
                        acc_d    = '0;
                        idx_d    = '0;
                        state_d  = MAC;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                MAC: begin
                    acc_d = sum_s;
                    if (idx_q == LAST_IDX) begin
                        out_data_d = sum_s;
                        idx_d      = '0;
                        state_d    = HOLD;
                    end else begin
                        idx_d      = idx_q + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                HOLD: begin
                    if (out_ready && out_valid_q) begin
                        wp_d    = wp_next_s;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control and datapath registers; handshake flags follow the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= (state_d == HOLD);
            in_ready_q  <= (state_d == IDLE);
        end
    end

    // Circular delay line, zeroed by clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAPS; k++) dly_q[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < NTAPS; k++) dly_q[k] <= '0;
        end else if (dly_we_s) begin
            dly_q[wp_q] <= in_sample;
        end
    end

    // Coefficient store survives clr; only reset zeroes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAPS; k++) coef_q[k] <= '0;
        end else if (coef_we_s) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_serial.sv
// Scoreboard bench for fir_serial: an 8-tap instance under directed and random stimulus,
// plus a 74-tap instance driven at full scale.
module tb_fir_serial;
    localparam int N   = 8;
    localparam int OW  = 16 + 16 + 3;
    localparam int N2  = 74;
    localparam int OW2 = 16 + 16 + 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    logic                 clr = 1'b0, in_valid = 1'b0, in_ready, coef_we = 1'b0, out_valid;
    logic signed [15:0]   in_sample = 16'sd0, coef_data = 16'sd0;
    logic [2:0]           coef_addr = 3'd0;
    logic signed [OW-1:0] out_data;
    logic                 out_ready, rand_rdy = 1'b0, rr = 1'b0, rdy_cmd = 1'b1;
    assign out_ready = rand_rdy ? rr : rdy_cmd;

    logic                  b_clr = 1'b0, b_in_valid = 1'b0, b_in_ready, b_coef_we = 1'b0, b_out_valid;
    logic                  b_out_ready = 1'b1;
    logic signed [15:0]    b_in_sample = 16'sd0, b_coef_data = 16'sd0;
    logic [6:0]            b_coef_addr = 7'd0;
    logic signed [OW2-1:0] b_out_data;

    fir_serial #(.NTAPS(N), .DW(16), .CW(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_sample(in_sample), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

    fir_serial #(.NTAPS(N2), .DW(16), .CW(16)) dut74 (
        .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sample(b_in_sample), .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data));

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1 rr = 1'($urandom_range(0, 1));
    end

    typedef struct { longint val; int t; } exp_t;
    exp_t     q[$];
    longint   q2[$];
    longint   hist[$];
    int       coef_m[N];

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // y[n] = sum coef[k]*x[n-k] over the samples seen since the last clear
    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < hist.size(); k++) s += longint'(coef_m[k]) * hist[k];
        return s;
    endfunction

    task automatic send(int x);
        bit got = 1'b0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_sample = 16'(x);
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                hist.push_front(longint'(x));
                if (hist.size() > N) void'(hist.pop_back());
                q.push_back('{model_y(), cyc + 1});
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic write_coef(int addr, int data, bit honoured);
        @(posedge clk); #1;
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 16'(data);
        @(posedge clk); #1;
        coef_we = 1'b0;
        if (honoured) coef_m[addr] = data;
    endtask

    task automatic wait_drain();
        int i = 0;
        while (q.size() != 0 && i < 1000) begin
            @(negedge clk);
            i++;
        end
        if (q.size() != 0) chk("drain_timeout", longint'(q.size()), 0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor for the 8-tap instance
    logic   prev_v = 1'b0;
    longint held = 0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                chk("in_ready_low_in_hold", longint'(in_ready), 0);
                if (!prev_v) begin
                    if (q.size() == 0) chk("unexpected_output", 1, 0);
                    else begin
                        chk("out_data", out_data, q[0].val);
                        chk("latency", longint'(cyc), longint'(q[0].t + N));
                    end
                    held = out_data;
                end else begin
                    chk("hold_stable", out_data, held);
                end
                if (out_ready && q.size() > 0) void'(q.pop_front());
            end
            prev_v = out_valid;
        end
    end

    // Monitor for the 74-tap instance
    always @(negedge clk) begin
        if (rst && b_out_valid && b_out_ready) begin
            if (q2.size() == 0) chk("fs_unexpected", 1, 0);
            else chk("fs_out", b_out_data, q2.pop_front());
        end
    end

    initial begin
        bit got;
        for (int k = 0; k < N; k++) coef_m[k] = 0;
        #1;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", longint'(in_ready), 1);

        // Impulse response with coef[k]=k+1
        for (int k = 0; k < N; k++) write_coef(k, k + 1, 1'b1);
        send(1);
        for (int i = 0; i < N; i++) send(0);
        wait_drain();

        // Write during MAC is dropped; the same write in IDLE applies next sample
        send(3);
        write_coef(0, 100, 1'b0);
        wait_drain();
        write_coef(0, 100, 1'b1);
        send(2);
        wait_drain();

        // Backpressure: output held, second sample waits
        rdy_cmd = 1'b0;
        send(-1234);
        fork
            send(777);
            begin
                repeat (N + 6) @(posedge clk);
                #1 rdy_cmd = 1'b1;
            end
        join
        wait_drain();

        // Randomised phase with random out_ready and occasional coefficient loads
        rand_rdy = 1'b1;
        for (int n = 0; n < 30; n++) begin
            logic signed [15:0] v;
            if ($urandom_range(0, 3) == 0) begin
                wait_drain();
                v = 16'($urandom);
                write_coef(int'($urandom_range(0, N - 1)), int'(v), 1'b1);
            end
            v = 16'($urandom);
            send(int'(v));
        end
        wait_drain();
        rand_rdy = 1'b0;

        // clr in HOLD after a step of 5 with unit coefficients
        for (int k = 0; k < N; k++) write_coef(k, 1, 1'b1);
        for (int i = 0; i < 3; i++) send(5);
        wait_drain();
        rdy_cmd = 1'b0;
        send(5);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = out_valid;
        end
        if (!got) chk("hold_timeout", 0, 1);
        @(posedge clk); #1 clr = 1'b1;
        @(negedge clk);
        q.delete();
        hist.delete();
        @(posedge clk); #1 clr = 1'b0;
        chk("clr_out_valid", longint'(out_valid), 0);
        chk("clr_out_data", out_data, 0);
        chk("clr_in_ready", longint'(in_ready), 1);
        rdy_cmd = 1'b1;
        send(1);
        wait_drain();

        // Full-scale run on the 74-tap instance
        @(posedge clk); #1 b_coef_we = 1'b1;
        for (int a = 0; a < N2; a++) begin
            b_coef_addr = 7'(a);
            b_coef_data = 16'sh8000;
            @(posedge clk); #1;
        end
        b_coef_we = 1'b0;
        for (int n = 1; n <= N2 + 2; n++) begin
            @(posedge clk); #1;
            b_in_valid  = 1'b1;
            b_in_sample = 16'sh8000;
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (b_in_ready) begin
                    got = 1'b1;
                    q2.push_back(longint'((n < N2) ? n : N2) * (longint'(1) << 30));
                end
            end
            @(posedge clk); #1 b_in_valid = 1'b0;
            if (!got) chk("fs_accept_timeout", 0, 1);
        end
        for (int i = 0; i < 200 && q2.size() != 0; i++) @(negedge clk);
        chk("fs_drained", longint'(q2.size()), 0);

        // Asynchronous reset mid-MAC
        send(7);
        @(posedge clk); #3;
        rst = 1'b0;
        q.delete();
        hist.delete();
        for (int k = 0; k < N; k++) coef_m[k] = 0;
        #1;
        chk("arst_in_ready", longint'(in_ready), 0);
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_out_data", out_data, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("arst_in_ready_rise", longint'(in_ready), 1);
        send(1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_serial.md
Name: fir_serial

Overview:
- Parametrised, time-multiplexed successor to the fully parallel 74-tap FIR.
- A single signed multiply-accumulate unit computes one output over NTAPS cycles.
- Adds runtime-loadable coefficients, valid/ready handshakes on input and output, and a synchronous delay-line clear.
- Sits in the DSP sample path between the sample source and downstream consumers, where the sample rate is well below clk/NTAPS.

Parameters:
- NTAPS, 74, number of taps (>=2).
- DW, 16, signed sample width.
- CW, 16, signed coefficient width.
- OW, DW+CW+$clog2(NTAPS), signed output width. Full precision; must not be set smaller.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of delay line and datapath.
- in_valid  in  1  in_sample is valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_sample  in  DW  signed input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(NTAPS)  coefficient index.
- coef_data  in  CW  signed coefficient value.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes out_data.
- out_data  out  OW  signed filter output.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst=0, all of the following are cleared:
  - state=IDLE; delay line, all coefficients, write pointer, tap index and accumulator are 0.
  - in_ready=0, out_valid=0, out_data=0.
  - in_ready rises on the first clock edge after rst deasserts.
- Function: y[n] = sum over k=0..NTAPS-1 of coef[k]*x[n-k]. coef[0] weights the newest sample.
- Arithmetic: signed products of width DW+CW, sign-extended into an OW-bit accumulator. No rounding, saturation or wrap is possible at the stated OW.
- Delay line: NTAPS-entry circular buffer addressed by wp.
  - Accept writes x[n] at wp.
  - Tap k reads entry (wp-k) mod NTAPS.
  - wp advances mod NTAPS after each completed output. Wrap-around at NTAPS-1 -> 0 is required.
- FSM states: IDLE, MAC, HOLD.
  - IDLE: in_ready=1. On in_valid=1: write the sample, acc=0, idx=0, go to MAC.
  - MAC: in_ready=0. Each cycle acc += buf[(wp-idx) mod NTAPS] * coef[idx], then idx++. After the idx=NTAPS-1 term, register the final sum into out_data, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1 and out_data held stable until out_ready=1. On that edge, out_valid=0, wp advances, go to IDLE.
- Latency: a sample accepted at edge t produces out_valid=1 after edge t+NTAPS. Throughput is at most one sample per NTAPS+2 cycles.
- Backpressure: out_ready=0 holds the block in HOLD indefinitely; in_ready stays 0 and no sample is lost.
- Coefficients: coef_we is honoured only in IDLE.
  - coef_we in MAC or HOLD is ignored (no effect).
  - coef_addr >= NTAPS is ignored.
  - A write takes effect from the next accepted sample.
- clr=1 applies in any state and has priority over the handshake and over coef_we:
  - delay line, acc and wp are zeroed; out_valid=0; state goes to IDLE.
  - Coefficients are retained.
  - A sample presented in the same cycle is dropped.
- Reset asserted mid-MAC or mid-HOLD: all state clears immediately and the partial result is discarded.
- out_data changes only on the MAC->HOLD transition, or on clr or reset (to 0).

Test Plan (NTAPS=8, DW=CW=16 unless stated):
- Impulse: load coef[k]=k+1, feed 1 then 8 zeros with out_ready=1 -> outputs 1,2,3,4,5,6,7,8,0. Each out_valid occurs NTAPS cycles after its accept.
- Full-scale, NTAPS=74: all coefs -32768, feed 74 samples of -32768 -> 74th output = 79456894976, no overflow. Wrap of wp is exercised.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_data stable, in_ready=0, in_valid samples not accepted. The output is released on the out_ready edge.
- Coefficient write in MAC: write coef[0]=100 mid-computation -> current output uses the old value and the write is dropped. The same write in IDLE takes effect on the next sample.
- clr: after a step input of 5 with coef all 1, assert clr in HOLD -> out_valid=0. The next impulse of 1 yields 1 (history cleared, coefficients kept).
- Async reset: assert rst=0 mid-MAC between edges -> all outputs 0 immediately. After release, in_ready=1 on the first edge and coefficients read as 0 (impulse -> output 0).
